// File: rtl/rom_upload.sv
// rom_upload: serves HPS ioctl upload reads by fetching bytes from boot, character and cartridge memories
//   CLK_SYS, RST_N        : system clock, asynchronous active-low reset
//   IOCTL_UPLOAD/INDEX/RD/ADDR : HPS upload session, image index, read strobe, byte address
//   IOCTL_DIN, IOCTL_WAIT : byte returned to the HPS, stall while a read is in flight
//   ROMRD_SEL_*/ADDR/REQ  : memory arbiter read request (target, local address, level request)
//   ROMRD_ACK/DATA        : arbiter acknowledge with read data
//   ROMRD_ERR             : sticky timeout flag, cleared by reset or a new upload session
module rom_upload #(
  parameter logic [15:0] UPLOAD_INDEX = 16'h0000,
  parameter logic [26:0] CART_LIMIT = 27'h20000,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK_SYS,
  input  logic        RST_N,
  input  logic        IOCTL_UPLOAD,
  input  logic [15:0] IOCTL_INDEX,
  input  logic        IOCTL_RD,
  input  logic [26:0] IOCTL_ADDR,
  output logic [7:0]  IOCTL_DIN,
  output logic        IOCTL_WAIT,
  output logic        ROMRD_SEL_BOOT,
  output logic        ROMRD_SEL_CHR,
  output logic        ROMRD_SEL_CART,
  output logic [16:0] ROMRD_ADDR,
  output logic        ROMRD_REQ,
  input  logic        ROMRD_ACK,
  input  logic [7:0]  ROMRD_DATA,
  output logic        ROMRD_ERR
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic [7:0] din_n;
  logic wait_n, req_n, err_n, upload_q, hit, is_boot, is_chr;
  logic [2:0] sel, sel_n;
  logic [16:0] addr_n;
  logic [15:0] cnt, cnt_n;
  assign hit = IOCTL_INDEX == UPLOAD_INDEX && IOCTL_ADDR < CART_LIMIT;
  assign is_boot = IOCTL_ADDR < 27'h1000;
  assign is_chr = IOCTL_ADDR < 27'h1400;
  assign {ROMRD_SEL_BOOT, ROMRD_SEL_CHR, ROMRD_SEL_CART} = sel;
  always_comb begin
    state_n = state;
    din_n = IOCTL_DIN;
    wait_n = IOCTL_WAIT;
    req_n = ROMRD_REQ;
    sel_n = sel;
    addr_n = ROMRD_ADDR;
    cnt_n = cnt;
    err_n = IOCTL_UPLOAD && !upload_q ? 1'b0 : ROMRD_ERR;
    case (state)
      IDLE: if (IOCTL_RD && IOCTL_UPLOAD) begin
        wait_n = 1'b1;
        if (hit) begin
          state_n = REQ;
          req_n = 1'b1;
          cnt_n = '0;
          sel_n = is_boot ? 3'b100 : is_chr ? 3'b010 : 3'b001;
          addr_n = is_boot ? {5'b0, IOCTL_ADDR[11:0]} : is_chr ? {7'b0, IOCTL_ADDR[9:0]} : IOCTL_ADDR[16:0];
        end else begin
          state_n = DONE;
          din_n = 8'hFF;
        end
      end
      REQ: begin
        cnt_n = cnt + 16'd1;
        if (!IOCTL_UPLOAD) begin
          // session ended mid-read: drop everything, keep the last byte
          state_n = IDLE;
          req_n = 1'b0;
          sel_n = '0;
          wait_n = 1'b0;
        end else if (ROMRD_ACK || cnt == LAST) begin
          // an ACK on the timeout cycle still delivers its data
          state_n = DONE;
          req_n = 1'b0;
          sel_n = '0;
          din_n = ROMRD_ACK ? ROMRD_DATA : 8'hFF;
          err_n = ROMRD_ACK ? err_n : 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        wait_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK_SYS or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      IOCTL_DIN <= 8'hFF;
      IOCTL_WAIT <= 1'b0;
      ROMRD_REQ <= 1'b0;
      sel <= '0;
      ROMRD_ADDR <= '0;
      ROMRD_ERR <= 1'b0;
      cnt <= '0;
      upload_q <= 1'b0;
    end else begin
      state <= state_n;
      IOCTL_DIN <= din_n;
      IOCTL_WAIT <= wait_n;
      ROMRD_REQ <= req_n;
      sel <= sel_n;
      ROMRD_ADDR <= addr_n;
      ROMRD_ERR <= err_n;
      cnt <= cnt_n;
      upload_q <= IOCTL_UPLOAD;
    end
  end
endmodule
